// File: rtl/digit_serial_alu_loop.sv
// digit_serial_alu_loop
//   Digit-serial ALU sequencer. One DIGIT_W-bit ALU slice is stepped across
//   the active digits (0..len) of two words, one digit per clock. The slice
//   supports ADD, SUB, AND, OR, XOR, LSHFT and RSHFT. A single flop holds the
//   carry/borrow or the shifted bit between digits. Result digits above len
//   keep the value loaded from preinit_result.
//
//   Ports
//     clk, rst        clock (rising edge), asynchronous active-high reset
//     start           operation request, accepted only in IDLE
//     cmd             0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LSHFT, 6 RSHFT, 7 ADD
//     len             index of the last active digit
//     sign_ext        RSHFT: arithmetic when 1, logical when 0
//     word1, word2    operands A and B (B is unused by the shifts)
//     preinit_result  value for the result digits above len
//     busy            high while digits are being processed
//     done            one-cycle pulse when result/carry_out are valid
//     result          result word, held until the next accepted start
//     carry_out       final carry / no-borrow / shifted-out bit (0 for logic ops)
//
//   Optional feature: define DSA_FLAGS_EN to add zero/neg/ovf status outputs.
//   These update together with done and are held afterwards.
module digit_serial_alu_loop #(
  parameter int  DIGIT_W    = 4,
  parameter int  NUM_DIGITS = 8,
  localparam int WORD_W     = DIGIT_W * NUM_DIGITS,
  localparam int LEN_W      = $clog2(NUM_DIGITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        cmd,
  input  logic [LEN_W-1:0]  len,
  input  logic              sign_ext,
  input  logic [WORD_W-1:0] word1,
  input  logic [WORD_W-1:0] word2,
  input  logic [WORD_W-1:0] preinit_result,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result,
`ifdef DSA_FLAGS_EN
  output logic              zero,
  output logic              neg,
  output logic              ovf,
`endif
  output logic              carry_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_LSHFT = 3'd5,
    OP_RSHFT = 3'd6,
    OP_ADD7  = 3'd7
  } op_e;

  // Digit-indexed view of a word: w[i] is digit i.
  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] word_t;

  state_e           state_q, state_n;
  op_e              cmd_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  word_t            a_q, b_q, result_q;
  logic             carry_q;
  logic             carry_out_q;

  word_t            word1_v;
  logic [DIGIT_W-1:0] a_dig, b_dig, b_eff, digit;
  logic [DIGIT_W:0]   sum;
  logic               carry_n;
  logic               last;
  word_t              result_n;

  assign word1_v = word1;

  // Digit slice plus bookkeeping for the current counter position.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a variable unassigned and infer a latch.
  always_comb begin
    a_dig    = a_q[cnt_q];
    b_dig    = b_q[cnt_q];
    b_eff    = (cmd_q == OP_SUB) ? ~b_dig : b_dig;
    sum      = {1'b0, a_dig} + {1'b0, b_eff} + (DIGIT_W+1)'(carry_q);
    digit    = '0;
    carry_n  = 1'b0;
    unique case (cmd_q)
      OP_AND: digit = a_dig & b_dig;
      OP_OR:  digit = a_dig | b_dig;
      OP_XOR: digit = a_dig ^ b_dig;
      OP_LSHFT: begin
        digit    = a_dig << 1;
        digit[0] = carry_q;
        carry_n  = a_dig[DIGIT_W-1];
      end
      OP_RSHFT: begin
        digit            = a_dig >> 1;
        digit[DIGIT_W-1] = carry_q;
        carry_n          = a_dig[0];
      end
      default: begin  // ADD, SUB and the cmd=7 alias of ADD
        digit   = sum[DIGIT_W-1:0];
        carry_n = sum[DIGIT_W];
      end
    endcase
    result_n        = result_q;
    result_n[cnt_q] = digit;
    // RSHFT walks from digit len down to 0 so each digit can pull in the
    // bit dropped by the digit above it; everything else walks upwards.
    last = (cmd_q == OP_RSHFT) ? (cnt_q == '0) : (cnt_q == len_q);
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_n = S_RUN;
      S_RUN:  if (last)  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

`ifdef DSA_FLAGS_EN
  logic zero_q, neg_q, ovf_q;
  logic zero_n, ovf_n;

  always_comb begin
    zero_n = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i <= int'(len_q) && result_n[i] != '0) zero_n = 1'b0;
    end
    // Signed overflow: both addends share a sign that the sum does not.
    // Only meaningful on the final (MSB) digit of an ADD/SUB.
    ovf_n = (cmd_q != OP_AND) && (cmd_q != OP_OR) && (cmd_q != OP_XOR) &&
            (cmd_q != OP_LSHFT) && (cmd_q != OP_RSHFT) &&
            (a_dig[DIGIT_W-1] == b_eff[DIGIT_W-1]) &&
            (sum[DIGIT_W-1] != a_dig[DIGIT_W-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == S_RUN && last) begin
      zero_q <= zero_n;
      neg_q  <= result_n[len_q][DIGIT_W-1];
      ovf_q  <= ovf_n;
    end
  end

  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order. The operand
  // registers are reset along with the control state, so nothing carries an
  // undefined value out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= OP_ADD;
      len_q       <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      state_q <= state_n;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            cmd_q    <= op_e'(cmd);
            len_q    <= len;
            a_q      <= word1;
            b_q      <= word2;
            result_q <= preinit_result;
            cnt_q    <= (op_e'(cmd) == OP_RSHFT) ? len : '0;
            if (op_e'(cmd) == OP_SUB)
              carry_q <= 1'b1;
            else if (op_e'(cmd) == OP_RSHFT)
              carry_q <= sign_ext & word1_v[len][DIGIT_W-1];
            else
              carry_q <= 1'b0;
          end
        end
        S_RUN: begin
          result_q <= result_n;
          carry_q  <= carry_n;
          if (last)
            carry_out_q <= carry_n;
          else if (cmd_q == OP_RSHFT)
            cnt_q <= cnt_q - LEN_W'(1);
          else
            cnt_q <= cnt_q + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_digit_serial_alu_loop.sv
// Self-checking bench for digit_serial_alu_loop (DIGIT_W=4, NUM_DIGITS=8).
// A table of operations is applied one after another; expected results are
// queued when an operation is started and compared when done pulses.
// Hand-written sequences cover start during RUN/DONE and reset mid-RUN.
module tb_digit_serial_alu_loop;

  localparam int DW = 4;
  localparam int ND = 8;
  localparam int WW = DW * ND;
  localparam int LW = $clog2(ND);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    cmd;
  logic [LW-1:0] len;
  logic          sign_ext;
  logic [WW-1:0] word1, word2, preinit_result;
  logic          busy, done, carry_out;
  logic [WW-1:0] result;
`ifdef DSA_FLAGS_EN
  logic          zero, neg, ovf;
`endif

  always #5 clk = ~clk;

  digit_serial_alu_loop #(.DIGIT_W(DW), .NUM_DIGITS(ND)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cmd            (cmd),
    .len            (len),
    .sign_ext       (sign_ext),
    .word1          (word1),
    .word2          (word2),
    .preinit_result (preinit_result),
    .busy           (busy),
    .done           (done),
    .result         (result),
`ifdef DSA_FLAGS_EN
    .zero           (zero),
    .neg            (neg),
    .ovf            (ovf),
`endif
    .carry_out      (carry_out)
  );

  typedef struct {
    string         name;
    logic [2:0]    cmd;
    logic [LW-1:0] len;
    logic          sign_ext;
    logic [WW-1:0] a;
    logic [WW-1:0] b;
    logic [WW-1:0] pre;
    logic [WW-1:0] exp_result;
    logic          exp_carry;
    logic          exp_zero;
    logic          exp_neg;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [WW-1:0] act,
                       input logic [WW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] c,
                              input int l, input logic se,
                              input logic [WW-1:0] a, input logic [WW-1:0] b,
                              input logic [WW-1:0] pre, input logic [WW-1:0] r,
                              input logic co, input logic z, input logic n,
                              input logic o);
    vec_t v;
    v.name = name; v.cmd = c; v.len = LW'(l); v.sign_ext = se;
    v.a = a; v.b = b; v.pre = pre; v.exp_result = r; v.exp_carry = co;
    v.exp_zero = z; v.exp_neg = n; v.exp_ovf = o;
    return v;
  endfunction

  // Drive one request on a negedge, queue its expectation, then scramble the
  // inputs right after the accepting edge to show they are no longer used.
  task automatic drive_start(input vec_t v);
    @(negedge clk);
    cmd = v.cmd; len = v.len; sign_ext = v.sign_ext;
    word1 = v.a; word2 = v.b; preinit_result = v.pre;
    start = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
    cmd = 3'($urandom_range(0, 7)); len = LW'($urandom_range(0, ND - 1));
    sign_ext = 1'($urandom_range(0, 1));
    word1 = $urandom; word2 = $urandom; preinit_result = $urandom;
  endtask

  // Wait (bounded) for done, count busy cycles, compare against the queue
  // head, then confirm done was a single pulse and the FSM went idle.
  task automatic wait_done();
    int   busy_cycles = 0;
    bit   seen = 1'b0;
    vec_t e;
    logic [WW-1:0] held;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) busy_cycles++;
    end
    check("done_seen", WW'(seen), WW'(1));
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", WW'(0), WW'(1));
      return;
    end
    e = sb.pop_front();
    if (!seen) return;
    check({e.name, "_result"},    result, e.exp_result);
    check({e.name, "_carry"},     WW'(carry_out), WW'(e.exp_carry));
    check({e.name, "_busy_cyc"},  WW'(busy_cycles), WW'(int'(e.len) + 1));
    check({e.name, "_busy_done"}, WW'(busy), WW'(0));
`ifdef DSA_FLAGS_EN
    check({e.name, "_zero"}, WW'(zero), WW'(e.exp_zero));
    check({e.name, "_neg"},  WW'(neg),  WW'(e.exp_neg));
    check({e.name, "_ovf"},  WW'(ovf),  WW'(e.exp_ovf));
`endif
    held = result;
    @(negedge clk);
    check({e.name, "_done_pulse"}, WW'(done), WW'(0));
    check({e.name, "_idle"},       WW'(busy), WW'(0));
    check({e.name, "_held"},       result, held);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; start = 1'b0; cmd = '0; len = '0; sign_ext = 1'b0;
    word1 = '0; word2 = '0; preinit_result = '0;

    //          name        cmd  len se  A             B             preinit       result        co  z  n  o
    vecs.push_back(mk("add_l7",   3'd0, 7, 0, 32'h0EFF_FFFF, 32'h0000_0001, 32'h0,        32'h0F00_0000, 0, 0, 0, 0));
    vecs.push_back(mk("sub_2m3",  3'd1, 7, 0, 32'h0000_0002, 32'h0000_0003, 32'h0,        32'hFFFF_FFFF, 0, 0, 1, 0));
    vecs.push_back(mk("sub_5m5",  3'd1, 7, 0, 32'h0000_0005, 32'h0000_0005, 32'h1234_5678, 32'h0000_0000, 1, 1, 0, 0));
    vecs.push_back(mk("add_l1",   3'd0, 1, 0, 32'h0000_00FF, 32'h0000_0001, 32'hABCD_1200, 32'hABCD_1200, 1, 1, 0, 0));
    vecs.push_back(mk("rsh_log",  3'd6, 7, 0, 32'h0600_0000, 32'hDEAD_BEEF, 32'h0,        32'h0300_0000, 0, 0, 0, 0));
    vecs.push_back(mk("rsh_ari",  3'd6, 7, 1, 32'h8000_0001, 32'h0,        32'h0,        32'hC000_0000, 1, 0, 1, 0));
    vecs.push_back(mk("lsh_l7",   3'd5, 7, 0, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0,        32'h0000_0002, 1, 0, 0, 0));
    vecs.push_back(mk("xor_l7",   3'd4, 7, 0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0,        32'h0F0F_F0F0, 0, 0, 0, 0));
    vecs.push_back(mk("and_l3",   3'd2, 3, 0, 32'hFFFF_5A5A, 32'hEEEE_0FF0, 32'h1234_0000, 32'h1234_0A50, 0, 0, 0, 0));
    vecs.push_back(mk("or_l0",    3'd3, 0, 0, 32'h0000_0003, 32'h0000_000C, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, 0, 1, 0));
    vecs.push_back(mk("add7_ovf", 3'd7, 3, 0, 32'h0000_7FFF, 32'h0000_0001, 32'h0,        32'h0000_8000, 0, 0, 1, 1));
    vecs.push_back(mk("rsh_l3",   3'd6, 3, 1, 32'h5555_8002, 32'h0,        32'hAAAA_0000, 32'hAAAA_C001, 0, 0, 1, 0));
    vecs.push_back(mk("lsh_l2",   3'd5, 2, 0, 32'h0000_0F00, 32'h0,        32'h1234_5000, 32'h1234_5E00, 1, 0, 1, 0));
    vecs.push_back(mk("sub_ovf",  3'd1, 7, 0, 32'h8000_0000, 32'h0000_0001, 32'h0,        32'h7FFF_FFFF, 1, 0, 0, 1));

    // Reset state.
    #12;
    check("rst_busy",   WW'(busy),      WW'(0));
    check("rst_done",   WW'(done),      WW'(0));
    check("rst_result", result,         WW'(0));
    check("rst_carry",  WW'(carry_out), WW'(0));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive_start(vecs[i]);
      wait_done();
    end

    // start pulsed during RUN with other operands must be ignored.
    v = mk("run_start", 3'd0, 7, 0, 32'h1111_1111, 32'h2222_2222, 32'h0,
           32'h3333_3333, 0, 0, 0, 0);
    drive_start(v);
    fork
      wait_done();
      begin
        @(negedge clk);
        start = 1'b1; cmd = 3'd4; len = LW'(2);
        word1 = 32'hFFFF_FFFF; word2 = 32'h0F0F_0F0F; preinit_result = 32'h5A5A_5A5A;
        repeat (3) @(negedge clk);
        start = 1'b0;
      end
    join

    // start in the same cycle as done must be ignored (no RUN follows).
    v = mk("done_start", 3'd0, 0, 0, 32'h0000_0009, 32'h0000_0008, 32'hF000_0000,
           32'hF000_0001, 1, 0, 0, 0);
    drive_start(v);
    fork
      wait_done();
      begin
        repeat (2) @(negedge clk);
        start = 1'b1; cmd = 3'd1; len = LW'(7);
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    @(negedge clk);
    check("done_start_no_run", WW'(busy), WW'(0));

    // Asynchronous reset in the middle of an ADD clears everything at once.
    v = mk("rst_mid", 3'd0, 7, 0, 32'h0123_4567, 32'h1111_1111, 32'hFFFF_FFFF,
           32'h1234_5678, 0, 0, 0, 0);
    drive_start(v);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy",   WW'(busy),      WW'(0));
    check("mid_rst_done",   WW'(done),      WW'(0));
    check("mid_rst_result", result,         WW'(0));
    check("mid_rst_carry",  WW'(carry_out), WW'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;

    v = mk("post_rst", 3'd0, 0, 0, 32'h0000_0001, 32'h0000_0001, 32'h0,
           32'h0000_0002, 0, 0, 0, 0);
    drive_start(v);
    wait_done();

    check("sb_drained", WW'(sb.size()), WW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
